pixel_feeder: RTL



---
 rtl/pixel_feeder_if.sv | 64 ++++++
 rtl/pixel_feeder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_feeder_if.sv
// pixel_feeder_if
// ----------------------------------------------------------------------------
// Groups the pixel_feeder streaming signals into one bundle.
//   Raw pixel input stream : in_valid, in_pixel, in_sof  (towards the feeder)
//                            in_ready                    (from the feeder)
//   Chip load handshake    : chip_ready                  (towards the feeder)
//   Burst output           : pixel_out0..4, out_valid, load_end, busy
//                                                        (from the feeder)
// Modports:
//   slave  - the pixel_feeder itself
//   master - whoever drives the raw stream and observes the burst
// ----------------------------------------------------------------------------
interface pixel_feeder_if #(
    parameter int IN_WIDTH   = 8,
    parameter int BIT_LENGTH = 5
) ();

    logic                  in_valid;
    logic [IN_WIDTH-1:0]   in_pixel;
    logic                  in_sof;
    logic                  in_ready;
    logic                  chip_ready;
    logic [BIT_LENGTH-1:0] pixel_out0;
    logic [BIT_LENGTH-1:0] pixel_out1;
    logic [BIT_LENGTH-1:0] pixel_out2;
    logic [BIT_LENGTH-1:0] pixel_out3;
    logic [BIT_LENGTH-1:0] pixel_out4;
    logic                  out_valid;
    logic                  load_end;
    logic                  busy;

    modport slave (
        input  in_valid,
        input  in_pixel,
        input  in_sof,
        input  chip_ready,
        output in_ready,
        output pixel_out0,
        output pixel_out1,
        output pixel_out2,
        output pixel_out3,
        output pixel_out4,
        output out_valid,
        output load_end,
        output busy
    );

    modport master (
        output in_valid,
        output in_pixel,
        output in_sof,
        output chip_ready,
        input  in_ready,
        input  pixel_out0,
        input  pixel_out1,
        input  pixel_out2,
        input  pixel_out3,
        input  pixel_out4,
        input  out_valid,
        input  load_end,
        input  busy
    );

endinterface

// File: rtl/pixel_feeder.sv
// pixel_feeder
// ----------------------------------------------------------------------------
// Upstream stage of the edge-detection chip. Accepts one raw pixel per cycle,
// quantizes it to BIT_LENGTH bits, buffers one IMG_DIM x IMG_DIM frame, then
// replays the frame as a gap-free burst of LANES pixels per cycle.
//
// Ports:
//   i_clk    - system clock
//   i_reset  - synchronous, active-high reset
//   io_bus   - pixel_feeder_if.slave:
//                in_valid/in_pixel/in_sof/in_ready : raw pixel stream
//                chip_ready                        : chip can take a burst
//                pixel_out0..4/out_valid/load_end  : registered burst lanes
//                busy                              : high while WAIT or BURST
// ----------------------------------------------------------------------------
module pixel_feeder #(
    parameter int IMG_DIM    = 20,
    parameter int BIT_LENGTH = 5,
    parameter int IN_WIDTH   = 8,
    parameter int LANES      = 5,
    parameter int ROUND      = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    pixel_feeder_if.slave io_bus
);

    localparam int NPIX   = IMG_DIM * IMG_DIM;
    localparam int NBEATS = NPIX / LANES;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int BEAT_W = $clog2(NBEATS + 1);
    localparam int SHIFT  = IN_WIDTH - BIT_LENGTH;

    localparam logic [IN_WIDTH:0] HALF =
        (SHIFT > 0) ? (IN_WIDTH+1)'(1 << (SHIFT - 1)) : (IN_WIDTH+1)'(0);
    localparam logic [IN_WIDTH:0] QMAX = (IN_WIDTH+1)'((1 << BIT_LENGTH) - 1);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] LANE_STEP = ADDR_W'(LANES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    // Round-to-nearest with saturation, or plain truncation to the MSBs.
    function automatic logic [BIT_LENGTH-1:0] quantize(input logic [IN_WIDTH-1:0] p);
        logic [IN_WIDTH:0] sum;
        logic [IN_WIDTH:0] shifted;
        sum     = {1'b0, p} + HALF;
        shifted = sum >> SHIFT;
        if (ROUND != 0) begin
            if (shifted > QMAX) begin
                quantize = QMAX[BIT_LENGTH-1:0];
            end else begin
                quantize = shifted[BIT_LENGTH-1:0];
            end
        end else begin
            quantize = p[IN_WIDTH-1 -: BIT_LENGTH];
        end
    endfunction

    logic [1:0]            r_state;
    logic [ADDR_W-1:0]     r_wr_cnt;
    logic [ADDR_W-1:0]     r_rd_addr;   // first buffer index of the next beat
    logic [BEAT_W-1:0]     r_beat;      // index of the next beat to present
    logic                  r_in_ready;
    logic                  r_busy;
    logic                  r_out_valid;
    logic                  r_load_end;
    logic [BIT_LENGTH-1:0] r_pix [LANES];
    logic [BIT_LENGTH-1:0] r_buf [NPIX];

    logic                  w_xfer;
    logic [BIT_LENGTH-1:0] w_q;
    logic [ADDR_W-1:0]     w_wr_addr;

    // Accepted-pixel decode, quantized value and write address (sof restarts at 0).
    always_comb begin
        w_xfer    = io_bus.in_valid & (r_state == S_FILL);
        w_q       = quantize(io_bus.in_pixel);
        w_wr_addr = io_bus.in_sof ? '0 : r_wr_cnt;
    end

    // Frame buffer write port; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_xfer) begin
            r_buf[w_wr_addr] <= w_q;
        end
    end

    // Control FSM with registered handshake and burst outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_FILL;
            r_wr_cnt    <= '0;
            r_rd_addr   <= '0;
            r_beat      <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_load_end  <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_pix[k] <= '0;
            end
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_xfer) begin
                        if (io_bus.in_sof) begin
                            // sof wins even on what would be the last pixel
                            r_wr_cnt <= ADDR_W'(1);
                        end else if (r_wr_cnt == LAST_IDX) begin
                            r_wr_cnt   <= '0;
                            r_state    <= S_WAIT;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (io_bus.chip_ready) begin
                        r_state     <= S_BURST;
                        r_out_valid <= 1'b1;
                        r_load_end  <= (NBEATS == 1);
                        for (int k = 0; k < LANES; k++) begin
                            r_pix[k] <= r_buf[ADDR_W'(k)];
                        end
                        r_rd_addr <= LANE_STEP;
                        r_beat    <= BEAT_W'(1);
                    end
                end
                S_BURST: begin
                    // chip_ready is deliberately ignored: the chip eats one beat per cycle
                    if (r_load_end) begin
                        r_state     <= S_FILL;
                        r_out_valid <= 1'b0;
                        r_load_end  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_rd_addr   <= '0;
                        r_beat      <= '0;
                        for (int k = 0; k < LANES; k++) begin
                            r_pix[k] <= '0;
                        end
                    end else begin
                        for (int k = 0; k < LANES; k++) begin
                            r_pix[k] <= r_buf[r_rd_addr + ADDR_W'(k)];
                        end
                        r_load_end <= (r_beat == LAST_BEAT);
                        r_rd_addr  <= r_rd_addr + LANE_STEP;
                        r_beat     <= r_beat + BEAT_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_FILL;
                    r_wr_cnt    <= '0;
                    r_rd_addr   <= '0;
                    r_beat      <= '0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_load_end  <= 1'b0;
                    for (int k = 0; k < LANES; k++) begin
                        r_pix[k] <= '0;
                    end
                end
            endcase
        end
    end

    assign io_bus.in_ready   = r_in_ready;
    assign io_bus.busy       = r_busy;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.load_end   = r_load_end;
    assign io_bus.pixel_out0 = r_pix[0];
    assign io_bus.pixel_out1 = r_pix[1];
    assign io_bus.pixel_out2 = r_pix[2];
    assign io_bus.pixel_out3 = r_pix[3];
    assign io_bus.pixel_out4 = r_pix[4];

endmodule
